// File: rtl/and_gate.sv
// and_gate: bitwise AND with registered copy, per-bit edge pulses, optional hit counter.
// Define AND_GATE_STATS_EN to build the saturating all-ones hit counter.
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [WIDTH-1:0] y_rise,
    output logic [WIDTH-1:0] y_fall,
    output logic             all_ones,
    output logic [CNT_W-1:0] hit_count
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("and_gate: WIDTH must be 1..64");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("and_gate: CNT_W must be 1..32");
    end

    logic [WIDTH-1:0] y_qq;

    assign y        = a & b;
    assign all_ones = &y;

    // Two-deep history of y for the edge detectors
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q  <= '0;
            y_qq <= '0;
        end else begin
            y_q  <= y;
            y_qq <= y_q;
        end
    end

    assign y_rise = y_q & ~y_qq;
    assign y_fall = ~y_q & y_qq;

`ifdef AND_GATE_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Count all-ones cycles, sticking at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (all_ones && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hit_count = cnt_q;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed vectors and sequences for and_gate.
// Counter expectations follow AND_GATE_STATS_EN.
module tb_and_gate;

`ifdef AND_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        a1, b1, y1, yq1, yr1, yf1, ao1;
    logic [15:0] hc1;

    logic [7:0]  a8, b8, y8, yq8, yr8, yf8;
    logic        ao8;
    logic [1:0]  hc8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    and_gate #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_q(yq1),
        .y_rise(yr1), .y_fall(yf1), .all_ones(ao1), .hit_count(hc1)
    );

    and_gate #(.WIDTH(8), .CNT_W(2)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y8), .y_q(yq8),
        .y_rise(yr8), .y_fall(yf8), .all_ones(ao8), .hit_count(hc8)
    );

    typedef struct {
        bit         wide;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       ones;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cexp(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    initial begin
        tbl[0] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 8'h01, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 8'h01, 8'h01, 8'h01, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 8'hxx, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'hF0, 8'h3C, 8'h30, 1'b0};
        tbl[6] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        tbl[7] = '{1'b1, 8'hAA, 8'h55, 8'h00, 1'b0};

        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        step();
        step();
        check("rst_yq1", yq1, 0);
        check("rst_rise1", yr1, 0);
        check("rst_fall1", yf1, 0);
        check("rst_hc1", hc1, 0);
        check("rst_yq8", yq8, 0);
        check("rst_hc8", hc8, 0);

        // combinational vectors, applied while reset is held
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wide) begin
                a8 = tbl[i].a;
                b8 = tbl[i].b;
                #2;
                check($sformatf("y8_v%0d", i), y8, tbl[i].y);
                check($sformatf("ao8_v%0d", i), ao8, tbl[i].ones);
            end else begin
                a1 = tbl[i].a[0];
                b1 = tbl[i].b[0];
                #10;
                check($sformatf("y1_v%0d", i), y1, tbl[i].y[0]);
                check($sformatf("ao1_v%0d", i), ao1, tbl[i].ones);
            end
        end

        a1 = 1'b0; b1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        step();
        rst = 1'b0;
        step();
        check("idle_yq1", yq1, 0);

        // edge pulses on the 1-bit instance
        a1 = 1'b1; b1 = 1'b1;
        step();
        check("e1_yq", yq1, 1);
        check("e1_rise", yr1, 1);
        check("e1_fall", yf1, 0);
        step();
        check("e2_yq", yq1, 1);
        check("e2_rise", yr1, 0);
        step();
        check("e3_rise", yr1, 0);
        a1 = 1'b0;
        #1;
        check("e3_y", y1, 0);
        check("e3_yq_hold", yq1, 1);
        step();
        check("e4_yq", yq1, 0);
        check("e4_fall", yf1, 1);
        check("e4_rise", yr1, 0);
        step();
        check("e5_fall", yf1, 0);
        check("e5_hc1", hc1, cexp(3));

        // saturating counter on the 8-bit instance
        a8 = 8'hFF; b8 = 8'hFF;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("sat_hc%0d", i), hc8,
                  cexp(i > 3 ? 3 : i));
        end

        // reset in the middle of counting
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        check("pre_hc", hc8, cexp(2));
        check("pre_yq", yq8, 8'hFF);
        rst = 1'b1;
        step();
        check("mid_yq", yq8, 0);
        check("mid_hc", hc8, 0);
        check("mid_rise", yr8, 0);
        check("mid_fall", yf8, 0);
        check("mid_y", y8, 8'hFF);
        rst = 1'b0;
        step();
        check("post_yq", yq8, 8'hFF);
        check("post_hc", hc8, cexp(1));
        check("post_rise", yr8, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
